mem_bist_ctrl: RTL and testbench

MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

---
 rtl/mem_bist_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist_ctrl.sv
// -----------------------------------------------------------------------------
// mem_bist_ctrl
// Memory built-in self-test sequencer. For each of four data patterns it writes
// every location, reads every location back, and compares the returned data
// one cycle after each read. It keeps a miscompare count and records the
// address, pattern index and data of the first miscompare of a run.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous reset, active-high
//   start      in   request a test run (ignored while busy)
//   busy       out  run in progress (WR/RD/DRAIN)
//   done       out  run finished, results valid (held until next accepted start)
//   pass       out  high in DONE when no miscompare was seen
//   err_count  out  number of miscompares in the run (saturating)
//   fail_addr  out  address of the first miscompare
//   fail_pat   out  pattern index of the first miscompare
//   fail_data  out  data read at the first miscompare
//   read       out  memory read strobe
//   write      out  memory write strobe
//   addr       out  memory address
//   data_in    out  write data to the memory
//   data_out   in   read data from the memory, valid the cycle after read
// -----------------------------------------------------------------------------
module mem_bist_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W+2:0] err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [1:0]        fail_pat,
  output logic [DATA_W-1:0] fail_data,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int ERR_W = ADDR_W + 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WR    = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0]  ERR_ZERO = {ERR_W{1'b0}};
  localparam logic [ERR_W-1:0]  ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

  // Test pattern for pattern index p at address a.
  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] p,
                                                input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] ext;
    ext = {DATA_W{1'b0}};
    ext[ADDR_W-1:0] = a;
    case (p)
      2'd0:    pattern = {DATA_W{1'b0}};
      2'd1:    pattern = ext;
      2'd2:    pattern = {DATA_W{1'b1}};
      2'd3:    pattern = ~ext;
      default: pattern = {DATA_W{1'b0}};
    endcase
  endfunction

  logic [2:0]        state_r;
  logic [ADDR_W-1:0] idx_r;
  logic [1:0]        pat_r;

  // Compare pipeline: describes the read issued in the previous cycle.
  logic              cmp_valid_r;
  logic [ADDR_W-1:0] cmp_addr_r;
  logic [1:0]        cmp_pat_r;
  logic [DATA_W-1:0] cmp_exp_r;

  logic              accept_s;
  logic              miscompare_s;
  logic              first_fail_s;
  logic              err_sat_s;

  // Start is only honoured from the idle/finished states.
  assign accept_s     = start && ((state_r == S_IDLE) || (state_r == S_DONE));
  assign miscompare_s = cmp_valid_r && (data_out != cmp_exp_r);
  assign first_fail_s = miscompare_s && (err_count == ERR_ZERO);
  assign err_sat_s    = &err_count;

  // Sequencer FSM; memory-side strobes/address/data are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      idx_r   <= IDX_ZERO;
      pat_r   <= 2'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      read    <= 1'b0;
      write   <= 1'b0;
      addr    <= IDX_ZERO;
      data_in <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_r <= S_WR;
            idx_r   <= IDX_ZERO;
            pat_r   <= 2'd0;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
            write   <= 1'b1;
            read    <= 1'b0;
            addr    <= IDX_ZERO;
            data_in <= pattern(2'd0, IDX_ZERO);
          end else begin
            state_r <= state_r;
          end
        end
        S_WR: begin
          if (idx_r == LAST_IDX) begin
            state_r <= S_RD;
            idx_r   <= IDX_ZERO;
            write   <= 1'b0;
            read    <= 1'b1;
            addr    <= IDX_ZERO;
          end else begin
            idx_r   <= idx_r + IDX_ONE;
            addr    <= idx_r + IDX_ONE;
            data_in <= pattern(pat_r, idx_r + IDX_ONE);
          end
        end
        S_RD: begin
          if (idx_r == LAST_IDX) begin
            // addr/data_in keep their last values while idle on the memory side
            state_r <= S_DRAIN;
            idx_r   <= IDX_ZERO;
            read    <= 1'b0;
          end else begin
            idx_r <= idx_r + IDX_ONE;
            addr  <= idx_r + IDX_ONE;
          end
        end
        S_DRAIN: begin
          if (pat_r == 2'd3) begin
            state_r <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            // the final compare resolves in this same cycle, so fold it in
            pass    <= (err_count == ERR_ZERO) && !miscompare_s;
          end else begin
            state_r <= S_WR;
            pat_r   <= pat_r + 2'd1;
            idx_r   <= IDX_ZERO;
            write   <= 1'b1;
            addr    <= IDX_ZERO;
            data_in <= pattern(pat_r + 2'd1, IDX_ZERO);
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          pass    <= 1'b0;
          read    <= 1'b0;
          write   <= 1'b0;
        end
      endcase
    end
  end

  // Compare pipeline and result capture: checks data_out against the read issued last cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_valid_r <= 1'b0;
      cmp_addr_r  <= IDX_ZERO;
      cmp_pat_r   <= 2'd0;
      cmp_exp_r   <= {DATA_W{1'b0}};
      err_count   <= ERR_ZERO;
      fail_addr   <= IDX_ZERO;
      fail_pat    <= 2'd0;
      fail_data   <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      cmp_valid_r <= 1'b0;
      err_count   <= ERR_ZERO;
      fail_addr   <= IDX_ZERO;
      fail_pat    <= 2'd0;
      fail_data   <= {DATA_W{1'b0}};
    end else begin
      cmp_valid_r <= read;
      cmp_addr_r  <= addr;
      cmp_pat_r   <= pat_r;
      cmp_exp_r   <= pattern(pat_r, addr);
      if (miscompare_s && !err_sat_s) begin
        err_count <= err_count + ERR_ONE;
      end else begin
        err_count <= err_count;
      end
      if (first_fail_s) begin
        fail_addr <= cmp_addr_r;
        fail_pat  <= cmp_pat_r;
        fail_data <= data_out;
      end else begin
        fail_addr <= fail_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_bist_ctrl
// Self-checking bench for mem_bist_ctrl with a 32x8 behavioural memory that can
// inject faults on its read data. Run results are table driven: each vector's
// expected result is queued when its start is driven and popped when done rises.
// -----------------------------------------------------------------------------
module tb_mem_bist_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [4:0] fail_addr;
  logic [1:0] fail_pat;
  logic [7:0] fail_data;
  logic       read;
  logic       write;
  logic [4:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;

  mem_bist_ctrl #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_addr (fail_addr),
    .fail_pat  (fail_pat),
    .fail_data (fail_data),
    .read      (read),
    .write     (write),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out)
  );

  typedef struct {
    int         fault;  // 0 none, 1 bit0 stuck-at-1 at addr 5, 2 data stuck at 00
    int         hold;   // cycles start is held high
    int         mid;    // run cycle at which start is pulsed again (-1 none)
    logic [7:0] err;
    logic [4:0] faddr;
    logic [1:0] fpat;
    logic [7:0] fdata;
    logic       pass;
  } vec_t;

  vec_t vecs[5];
  vec_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int rw_viol  = 0;
  int fault_mode = 0;

  logic [7:0] mem [0:31];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] tb_pattern(input logic [1:0] p, input logic [4:0] a);
    logic [7:0] z;
    z = {3'b000, a};
    case (p)
      2'd0:    return 8'h00;
      2'd1:    return z;
      2'd2:    return 8'hFF;
      default: return ~z;
    endcase
  endfunction

  function automatic logic [7:0] apply_fault(input int mode, input logic [4:0] a,
                                             input logic [7:0] d);
    case (mode)
      1:       return (a == 5'd5) ? (d | 8'h01) : d;
      2:       return 8'h00;
      default: return d;
    endcase
  endfunction

  // Behavioural memory with one-cycle read latency and fault injection on read data.
  always @(posedge clk) begin
    if (write) mem[addr] <= data_in;
    if (read)  data_out <= apply_fault(fault_mode, addr, mem[addr]);
  end

  // Strobe exclusivity monitor, active for the whole run.
  always @(negedge clk) begin
    if (read && write) rw_viol++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Drive one run from IDLE/DONE and compare everything at completion.
  task automatic run_vec(input vec_t v);
    int   cycles;
    int   wr;
    int   rd;
    int   seq_err;
    vec_t e;
    fault_mode = v.fault;
    exp_q.push_back(v);
    start = 1'b1;
    @(negedge clk);
    cycles = 0; wr = 0; rd = 0; seq_err = 0;
    chk("start_clears_err", err_count, 32'd0);
    chk("start_clears_fail", {fail_addr, fail_pat, fail_data}, 32'd0);
    chk("start_clears_done", done, 32'd0);
    while (busy && cycles < 400) begin
      if (write) begin
        if (addr != wr[4:0] || data_in != tb_pattern(wr[6:5], wr[4:0])) seq_err++;
        wr++;
      end
      if (read) begin
        if (addr != rd[4:0]) seq_err++;
        rd++;
      end
      if (pass || done) seq_err++;
      start = (cycles < v.hold - 1) || (cycles == v.mid);
      cycles++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_cycles", cycles, 32'd260);
    chk("write_cycles", wr, 32'd128);
    chk("read_cycles", rd, 32'd128);
    chk("seq_addr_data", seq_err, 32'd0);
    chk("done_set", done, 32'd1);
    chk("strobes_idle", {read, write}, 32'd0);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("err_count", err_count, {24'd0, e.err});
      chk("fail_addr", fail_addr, {27'd0, e.faddr});
      chk("fail_pat", fail_pat, {30'd0, e.fpat});
      chk("fail_data", fail_data, {24'd0, e.fdata});
      chk("pass", pass, {31'd0, e.pass});
    end
    repeat (3) @(negedge clk);
    chk("done_held", {busy, done}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{fault: 0, hold: 1, mid: -1, err: 8'd0,  faddr: 5'd0, fpat: 2'd0, fdata: 8'h00, pass: 1'b1};
    vecs[1] = '{fault: 1, hold: 1, mid: -1, err: 8'd2,  faddr: 5'd5, fpat: 2'd0, fdata: 8'h01, pass: 1'b0};
    // p0 matches, p1 fails everywhere except a=0 so the first miscompare is address 1
    vecs[2] = '{fault: 2, hold: 1, mid: -1, err: 8'd95, faddr: 5'd1, fpat: 2'd1, fdata: 8'h00, pass: 1'b0};
    // start held high in DONE after the failing run above
    vecs[3] = '{fault: 0, hold: 5, mid: -1, err: 8'd0,  faddr: 5'd0, fpat: 2'd0, fdata: 8'h00, pass: 1'b1};
    // start pulsed again at cycle 100 of the run
    vecs[4] = '{fault: 0, hold: 1, mid: 100, err: 8'd0, faddr: 5'd0, fpat: 2'd0, fdata: 8'h00, pass: 1'b1};

    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {busy, done, pass, read, write}, 32'd0);
    chk("reset_addr_data", {addr, data_in}, 32'd0);
    chk("reset_results", {err_count, fail_addr, fail_pat, fail_data}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_start", busy, 32'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset 40 cycles into a run with a failing memory.
    fault_mode = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    chk("pre_reset_busy", busy, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_reset_strobes", {read, write, busy}, 32'd0);
    chk("midrun_reset_err", err_count, 32'd0);
    chk("midrun_reset_all", {done, pass, addr, data_in, fail_addr, fail_pat, fail_data}, 32'd0);
    repeat (3) @(negedge clk);
    chk("after_reset_idle", {busy, err_count}, 32'd0);
    run_vec(vecs[0]);

    // Reset wins over a simultaneous start.
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("rst_priority_busy", {busy, write}, 32'd0);
    chk("rst_priority_done", done, 32'd0);
    @(negedge clk);
    chk("rst_priority_stays_idle", busy, 32'd0);

    chk("read_write_exclusive", rw_viol, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
